// File: rtl/dmem_ctrl.sv
// Data-memory controller: a single-port word array behind a valid/ready
// request channel and a valid/ready response channel. Supports byte,
// halfword and word loads/stores with sign/zero extension, flags misaligned,
// illegal-size and out-of-range accesses, and returns each response a fixed
// number of cycles after the request is accepted.
module dmem_ctrl #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    // Index width of the word array; kept at least 1 so a one-word memory still elaborates.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // WAIT counter start value; the counter only matters when LATENCY > 1.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;

    logic [31:0] mem [DEPTH];

    logic        accept;
    logic [AW-1:0] idx;
    logic [1:0]  lane;
    logic [31:0] word_idx;
    logic        fault;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;

    assign accept   = req_valid && req_ready;
    assign idx      = req_addr[AW+1:2];
    assign lane     = req_addr[1:0];
    assign word_idx = {2'b00, req_addr[31:2]};

    // Decide whether the presented request must be faulted instead of executed.
    always_comb begin
        fault = 1'b0;
        case (req_size)
            SIZE_BYTE: fault = 1'b0;
            SIZE_HALF: fault = req_addr[0];
            SIZE_WORD: fault = |req_addr[1:0];
            default:   fault = 1'b1;
        endcase
        if (word_idx >= 32'(DEPTH)) begin
            fault = 1'b1;
        end
    end

    // Pick the addressed lane(s) out of the stored word and extend to 32 bits.
    always_comb begin
        rd_word  = mem[idx];
        rd_byte  = 8'h00;
        rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = 32'h0000_0000;
        case (lane)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        case (req_size)
            SIZE_BYTE: load_val = req_unsigned ? {24'h000000, rd_byte}
                                               : {{24{rd_byte[7]}}, rd_byte};
            SIZE_HALF: load_val = req_unsigned ? {16'h0000, rd_half}
                                               : {{16{rd_half[15]}}, rd_half};
            SIZE_WORD: load_val = rd_word;
            default:   load_val = 32'h0000_0000;
        endcase
    end

    // Commit legal stores at their accept edge; the array is never reset so data survives a reset.
    always_ff @(posedge clk) begin
        if (accept && req_we && !fault) begin
            case (req_size)
                SIZE_BYTE: begin
                    case (lane)
                        2'd0:    mem[idx][7:0]   <= req_wdata[7:0];
                        2'd1:    mem[idx][15:8]  <= req_wdata[7:0];
                        2'd2:    mem[idx][23:16] <= req_wdata[7:0];
                        default: mem[idx][31:24] <= req_wdata[7:0];
                    endcase
                end
                SIZE_HALF: begin
                    if (lane[1]) begin
                        mem[idx][31:16] <= req_wdata[15:0];
                    end else begin
                        mem[idx][15:0] <= req_wdata[15:0];
                    end
                end
                SIZE_WORD: mem[idx] <= req_wdata;
                default: ;
            endcase
        end
    end

    // Request/response sequencing: capture the result at accept, count out the latency, hold until taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        rsp_err   <= fault;
                        rsp_rdata <= (fault || req_we) ? 32'h0000_0000 : load_val;
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        cnt       <= 4'd0;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0000_0000;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= 4'd0;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'h0000_0000;
                    rsp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with DEPTH = 64 and LATENCY = 3: load/store
// lane handling, extension, faults, response back-pressure and reset behaviour.
module tb_dmem_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total_checks  = 0;
    int passed_checks = 0;
    int failed_checks = 0;

    dmem_ctrl #(
        .DEPTH   (64),
        .LATENCY (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends even if the DUT wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it and reports the tag with observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) begin
            passed_checks++;
        end else begin
            failed_checks++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Full transaction with rsp_ready held high; garbage is driven on the request bus while busy.
    task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        logic [31:0] got_rdata;
        logic got_err;
        @(negedge clk);
        rsp_ready    = 1'b1;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        checkOutput($sformatf("%s_ready", tag), 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_we       = 1'b1;
        req_size     = 2'b10;
        req_unsigned = ~uns;
        req_addr     = addr ^ 32'h0000_0004;
        req_wdata    = 32'hBAD0_BAD0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        req_valid = 1'b0;
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
        checkOutput($sformatf("%s_lat", tag), 32'(lat), 32'd3);
        checkOutput($sformatf("%s_rdata", tag), got_rdata, exp_rdata);
        checkOutput($sformatf("%s_err", tag), 32'(got_err), 32'(exp_err));
        @(posedge clk);
        #1;
    endtask

    // Directed test sequence.
    initial begin
        int n;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        rsp_ready    = 1'b1;

        #3;
        $display("[TB] reset state");
        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rdata", rsp_rdata, 32'h0);
        checkOutput("rst_err", 32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        $display("[TB] word store/load latency");
        applyStimulus("st_dead", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        applyStimulus("ld_dead", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

        $display("[TB] sub-word loads and extension");
        applyStimulus("st_80ff", 1'b1, 2'b10, 1'b0, 32'h10, 32'h0000_80FF, 32'h0, 1'b0);
        applyStimulus("lb_10",   1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hFFFF_FFFF, 1'b0);
        applyStimulus("lbu_11",  1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h0000_0080, 1'b0);
        applyStimulus("lb_11",   1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFF_FF80, 1'b0);
        applyStimulus("lh_10",   1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFF_80FF, 1'b0);
        applyStimulus("lhu_12",  1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000_0000, 1'b0);

        $display("[TB] sub-word stores");
        applyStimulus("st_1122", 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 32'h0, 1'b0);
        applyStimulus("sb_12",   1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFF_FFAA, 32'h0, 1'b0);
        applyStimulus("ld_sb",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h11AA_3344, 1'b0);
        applyStimulus("sh_12",   1'b1, 2'b01, 1'b0, 32'h12, 32'h1234_BEEF, 32'h0, 1'b0);
        applyStimulus("ld_sh",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hBEEF_3344, 1'b0);
        applyStimulus("lhu_sh",  1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000_BEEF, 1'b0);

        $display("[TB] faults");
        applyStimulus("st_w0",   1'b1, 2'b10, 1'b0, 32'h00, 32'hCAFE_F00D, 32'h0, 1'b0);
        applyStimulus("sh_13",   1'b1, 2'b01, 1'b0, 32'h13, 32'h0000_5555, 32'h0, 1'b1);
        applyStimulus("lw_02",   1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 32'h0, 1'b1);
        applyStimulus("sz11_st", 1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
        applyStimulus("lw_100",  1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
        applyStimulus("sw_100",  1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
        applyStimulus("ld_w10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hBEEF_3344, 1'b0);
        applyStimulus("ld_w0",   1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'hCAFE_F00D, 1'b0);
        applyStimulus("st_last", 1'b1, 2'b10, 1'b0, 32'hFC, 32'h0BAD_CAFE, 32'h0, 1'b0);
        applyStimulus("ld_last", 1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, 32'h0BAD_CAFE, 1'b0);

        $display("[TB] response back-pressure");
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h10;
        @(posedge clk);
        #1;
        req_we    = 1'b1;
        req_wdata = 32'h0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_lat", 32'(n), 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'd1);
            checkOutput($sformatf("bp_rdata%0d", i), rsp_rdata, 32'hBEEF_3344);
            checkOutput($sformatf("bp_ready%0d", i), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("bp_ready_after", 32'(req_ready), 32'd1);
        checkOutput("bp_valid_after", 32'(rsp_valid), 32'd0);
        applyStimulus("ld_bp", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hBEEF_3344, 1'b0);

        $display("[TB] reset during WAIT and RESP");
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h20;
        req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rw_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rw_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("rw_valid_edge", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rr_pre_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rr_pre_rdata", rsp_rdata, 32'h1234_5678);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rr_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rr_rdata", rsp_rdata, 32'h0);
        checkOutput("rr_err", 32'(rsp_err), 32'd0);
        checkOutput("rr_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset     = 1'b0;
        rsp_ready = 1'b1;

        applyStimulus("ld_20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1234_5678, 1'b0);
        applyStimulus("ld_keep", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hBEEF_3344, 1'b0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The module SHALL have parameter DEPTH, default 64, giving the number of 32-bit words in the memory array.
REQ-002 The module SHALL have parameter LATENCY, default 1, giving the cycles from request accept to response valid; legal range is 1..8.
REQ-003 The ports SHALL be, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- req_unsigned  input  1  for loads, 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, LSB-aligned (byte in [7:0], halfword in [15:0]).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  32  load result; 0 for stores and errors.
- rsp_err  output  1  request was faulted.

Function
REQ-004 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-005 The FSM SHALL have the states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-006 On accept, the FSM SHALL go from IDLE to RESP when LATENCY = 1, otherwise from IDLE to WAIT with the counter loaded to LATENCY-1.
REQ-007 In WAIT the counter SHALL decrement each cycle; on reaching 1 the FSM SHALL go to RESP at the next edge.
REQ-008 rsp_valid SHALL first be 1 exactly LATENCY cycles after the accept edge.
REQ-009 In RESP, rsp_valid SHALL stay 1, and rsp_rdata and rsp_err SHALL hold stable, until an edge with rsp_ready = 1; the FSM SHALL then return to IDLE.
REQ-010 There SHALL be no accept in the same cycle as a response handshake; the next accept is possible at the earliest one cycle later.
REQ-011 Word index SHALL be req_addr[31:2]; byte lane SHALL be req_addr[1:0].
REQ-012 A fault SHALL be flagged when any of these holds: req_size = 11; halfword with req_addr[0] = 1; word with req_addr[1:0] != 00; word index >= DEPTH.
REQ-013 A faulted request SHALL set rsp_err = 1 and rsp_rdata = 0, and SHALL NOT modify memory.
REQ-014 A legal store SHALL write only the addressed lanes at the accept edge:
- byte: one lane, from wdata[7:0];
- halfword: lanes {1,0} or {3,2}, from wdata[15:0];
- word: all four lanes.
REQ-015 A store response SHALL have rsp_rdata = 0 and rsp_err = 0.
REQ-016 A legal load SHALL read the word at the accept edge, select the lane(s), and extend to 32 bits per req_unsigned; the result SHALL be registered until the response handshake.
REQ-017 A load that follows a store to the same word SHALL return the updated data, since the store commits at its own accept edge.
REQ-018 Request inputs SHALL be sampled only at the accept edge; changes at any other time SHALL have no effect.

Reset
REQ-019 While reset is high the FSM SHALL be IDLE, with counter = 0, req_ready = 1, rsp_valid = 0, rsp_rdata = 0 and rsp_err = 0, regardless of clk.
REQ-020 Reset asserted during WAIT or RESP SHALL discard the pending response; a store already committed at its accept edge SHALL remain in memory.
REQ-021 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-022 LATENCY = 3, word store 0xDEADBEEF to addr 0x10, then word load from addr 0x10 -> rsp_valid exactly 3 cycles after each accept; load rsp_rdata = 0xDEADBEEF, rsp_err = 0.
REQ-023 Word 0x10 = 0x000080FF:
- signed byte load from 0x10 -> 0xFFFFFFFF;
- unsigned byte load from 0x11 -> 0x00000080;
- signed halfword load from 0x10 -> 0xFFFF80FF.
REQ-024 Byte store 0xAA to addr 0x12 over word 0x11223344, then word load -> 0x11AA3344.
REQ-025 The following SHALL each give rsp_err = 1 and rsp_rdata = 0 with memory unchanged:
- halfword store to 0x13;
- word load from 0x02;
- req_size = 11;
- word load from 0x100 with DEPTH = 64.
REQ-026 Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stay stable and req_ready stays 0; set rsp_ready = 1 -> req_ready = 1 the following cycle.
REQ-027 Assert reset mid-WAIT after a word store 0x12345678 to 0x20 -> rsp_valid drops immediately; after release, a load from 0x20 returns 0x12345678.
